// File: rtl/frame_reader.sv
// Streams a finished frame out of the image BRAM into the output FIFO, absorbing the BRAM read latency.
// Optional grayscale output when FRAME_READER_GRAY_EN is defined.
module frame_reader #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int IMAGE_SIZE = WIDTH * HEIGHT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic [$clog2(IMAGE_SIZE)-1:0] bram_rd_addr,
    output logic                          bram_rd_en,
    input  logic [23:0]                   bram_rd_data,
    input  logic                          out_full,
    output logic                          out_wr_en,
    output logic [23:0]                   out_din,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int AW  = $clog2(IMAGE_SIZE);
    localparam int AW1 = AW + 1;
    localparam logic [AW:0] LAST = AW1'(IMAGE_SIZE - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

    state_t         state;
    logic [AW:0]    addr;        // one extra bit so the count can reach IMAGE_SIZE
    logic           inflt;
    pixel_t [1:0]   buf_q;
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     occ;

    logic           pop;
    logic           issue;
    logic [2:0]     credit_sum;
    pixel_t         head;

    // Occupancy the buffer could reach once this cycle's read returns.
    assign pop        = (occ != 2'd0) && !out_full;
    assign credit_sum = {1'b0, occ} + {2'b0, inflt} + 3'd1 - {2'b0, pop};
    assign issue      = (state == READ) && (addr <= LAST) && (credit_sum <= 3'd2);

    assign bram_rd_en   = issue;
    assign bram_rd_addr = issue ? addr[AW-1:0] : '0;
    assign out_wr_en    = pop;
    assign busy         = (state != IDLE);
    assign head         = buf_q[rd_ptr];

`ifdef FRAME_READER_GRAY_EN
    logic [9:0] gray_sum;
    assign gray_sum = {2'b0, head.r} + {1'b0, head.g, 1'b0} + {2'b0, head.b};
    assign out_din  = {3{gray_sum[9:2]}};
`else
    assign out_din  = head;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= '0;
            inflt      <= 1'b0;
            buf_q      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            inflt      <= issue;
            if (inflt) begin
                buf_q[wr_ptr] <= bram_rd_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflt} - {1'b0, pop};

            case (state)
                IDLE: begin
                    // A start landing on the done pulse belongs to the old frame.
                    if (start && !frame_done) begin
                        state <= READ;
                        addr  <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        addr <= addr + 1'b1;
                        if (addr == LAST)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflt && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader on a 4x2 frame: streaming, backpressure, ignored restart, reset abort.
module tb_frame_reader;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        out_full = 1'b0;
    logic [2:0]  bram_rd_addr;
    logic        bram_rd_en;
    logic [23:0] bram_rd_data = '0;
    logic        out_wr_en;
    logic [23:0] out_din;
    logic        busy;
    logic        frame_done;

    frame_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_en   (bram_rd_en),
        .bram_rd_data (bram_rd_data),
        .out_full     (out_full),
        .out_wr_en    (out_wr_en),
        .out_din      (out_din),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    logic [23:0] mem [N];
    always @(posedge clock) if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_px(input logic [23:0] p);
`ifdef FRAME_READER_GRAY_EN
        logic [9:0] s;
        s = {2'b0, p[7:0]} + {1'b0, p[15:8], 1'b0} + {2'b0, p[23:16]};
        return {3{s[9:2]}};
`else
        return p;
`endif
    endfunction

    logic [23:0] got_q[$];
    int first_t, done_cnt, done_t, done_busy, busy0, pend_max, full_err, addr_err, issued, rst_snap;

    // mode: 0 plain, 1 full t=3..7, 2 full on odd t, 3 restart at t=4, 4 reset at t=5
    task automatic run_frame(input int mode);
        int pend;
        got_q.delete();
        first_t = -1; done_cnt = 0; done_t = -1; done_busy = -1; busy0 = -1;
        pend_max = 0; full_err = 0; addr_err = 0; issued = 0; rst_snap = -1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int t = 0; t < 40; t++) begin
            case (mode)
                1:       out_full = (t >= 3 && t <= 7);
                2:       out_full = t[0];
                default: out_full = 1'b0;
            endcase
            start = (mode == 3 && t == 4);
            if (mode == 4 && t == 5) reset = 1'b0;
            if (mode == 4 && t == 8) reset = 1'b1;
            @(negedge clock);
            pend = issued - got_q.size();
            if (pend > pend_max) pend_max = pend;
            if (bram_rd_en) begin
                if (int'(bram_rd_addr) != issued) addr_err++;
                issued++;
            end else if (bram_rd_addr != 3'd0) addr_err++;
            if (out_full && out_wr_en) full_err++;
            if (out_wr_en) begin
                if (first_t < 0) first_t = t;
                got_q.push_back(out_din);
            end
            if (frame_done) begin
                done_cnt++;
                done_t = t;
                done_busy = int'(busy);
            end
            if (t == 0) busy0 = int'(busy);
            if (mode == 4 && t == 5)
                rst_snap = int'({out_wr_en, bram_rd_en, busy, frame_done, |out_din, |bram_rd_addr});
            @(posedge clock); #1;
        end
        out_full = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_count"}, got_q.size(), N);
        for (int i = 0; i < N; i++)
            if (i < got_q.size()) chk($sformatf("%s_px%0d", tag, i), got_q[i], exp_px(mem[i]));
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_pend_le2"}, pend_max <= 2, 1);
        chk({tag, "_wr_while_full"}, full_err, 0);
        chk({tag, "_addr_seq"}, addr_err, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 24'(i);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_rd_en", bram_rd_en, 0);
        chk("rst_rd_addr", bram_rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_din", out_din, 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        run_frame(0);
        check_frame("basic");
        chk("basic_first_t", first_t, 2);
        chk("basic_done_t", done_t, 10);
        chk("basic_done_busy", done_busy, 0);
        chk("basic_busy0", busy0, 1);

        run_frame(1);
        check_frame("bp");
        chk("bp_first_t", first_t, 2);
        chk("bp_done_t", done_t, 15);

        run_frame(2);
        check_frame("toggle");

        run_frame(3);
        check_frame("restart");
        chk("restart_first_t", first_t, 2);
        chk("restart_done_t", done_t, 10);

        run_frame(4);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_outputs", rst_snap, 0);
        chk("abort_partial", got_q.size(), 3);

        run_frame(0);
        check_frame("after_rst");
        chk("after_rst_first_t", first_t, 2);

        mem[0] = 24'h4080C0;
        run_frame(0);
        check_frame("pix0");
`ifdef FRAME_READER_GRAY_EN
        if (got_q.size() > 0) chk("gray_px0", got_q[0], 24'h808080);
`else
        if (got_q.size() > 0) chk("raw_px0", got_q[0], 24'h4080C0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Reads the finished frame back out of the image BRAM after the lane-highlight pass has completed.
- Walks the BRAM sequentially from address 0 to IMAGE_SIZE-1.
- Absorbs the 1-cycle BRAM read latency and streams 24-bit pixels into the downstream output FIFO (wr_en/full interface).
- Sits between the image BRAM and the frame-buffer/video-out FIFO. It is the read side of the BRAM that the highlight stage writes.

Parameters:
- WIDTH, 1280, image width in pixels.
- HEIGHT, 720, image height in pixels.
- IMAGE_SIZE, WIDTH*HEIGHT, number of pixels per frame.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse (hough/highlight done) that begins a frame read.
- bram_rd_addr  out  $clog2(IMAGE_SIZE)  image BRAM read address.
- bram_rd_en  out  1  read strobe; data valid on bram_rd_data exactly 1 cycle later.
- bram_rd_data  in  24  pixel data; R=[7:0], G=[15:8], B=[23:16].
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  write strobe to downstream FIFO.
- out_din  out  24  pixel to downstream FIFO.
- busy  out  1  high from the cycle after an accepted start until done.
- frame_done  out  1  one-cycle pulse after the last pixel is written.

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0; buffer empty; in-flight flag 0.
- States:
  - IDLE: wait for start=1, then go to READ with addr=0. start is ignored in every other state.
  - READ: issue reads while addr < IMAGE_SIZE and credit allows. After issuing IMAGE_SIZE reads, go to DRAIN.
  - DRAIN: no further reads. When the buffer is empty and nothing is in flight, pulse frame_done for one cycle and return to IDLE.
- Credit rule: internal 2-entry pixel buffer. A read is issued in a cycle only if (buffer occupancy + in-flight reads + this cycle's push) ≤ 2, accounting for a pop in the same cycle. This guarantees no returned data is ever dropped when out_full rises.
- Read cycle: a read asserts bram_rd_en=1, drives bram_rd_addr=addr, and sets addr←addr+1. The returned data is pushed into the buffer on the next cycle.
- Output rule: out_wr_en = (buffer not empty) && !out_full. out_din = buffer head, combinational from the buffer.
- Pop and push in the same cycle are both allowed; occupancy is unchanged.
- Ordering: pixels are written strictly in address order with no gaps, duplicates or reordering.
- Throughput: with out_full held 0, one pixel per cycle sustained. The first out_wr_en comes 2 cycles after start: start cycle → read issue → data to buffer → write.
- Backpressure: when out_full=1, no writes occur. At most 2 pixels are held, and reads stall until space frees up.
- Addressing: addr counts 0..IMAGE_SIZE-1 and never wraps within a frame. bram_rd_addr is 0 when bram_rd_en=0.
- busy is 1 in READ and DRAIN, 0 in IDLE. busy is 0 during the frame_done cycle, which is the IDLE-transition cycle.
- Reset asserted mid-frame: immediate return to IDLE, buffer cleared, in-flight data discarded, no frame_done pulse.
- start while busy: ignored, with no restart and no effect on the counter.
- start on the same cycle frame_done pulses: ignored. A new start must come from IDLE.

Optional Feature:
- Macro: FRAME_READER_GRAY_EN
- Defined: each pixel is converted to grayscale as it leaves the buffer.
  - gray = (R + 2*G + B) >> 2, computed at 10-bit width and truncated to 8 bits.
  - out_din = {gray, gray, gray}.
  - Conversion is combinational on the buffer head, so latency and throughput are unchanged.
- Undefined: out_din is the raw 24-bit BRAM pixel.

Test Plan:
- Basic frame, WIDTH=4, HEIGHT=2, BRAM[i]=24'h000000+i, out_full=0, pulse start → out_wr_en high for 8 consecutive cycles starting 2 cycles after start, out_din 0..7 in order; frame_done pulses once, the cycle after the last write; busy falls the same cycle.
- Backpressure: same frame, out_full=1 for cycles 3–7 after start → no writes while full, at most 2 reads outstanding/buffered, all 8 pixels delivered in order with no loss or duplicate, frame_done still single.
- Toggling full every cycle for the whole frame → exactly 8 writes with values 0..7, bram_rd_en never leaves more than 2 pixels pending.
- start re-pulsed at cycle 4 mid-frame → ignored: output sequence identical to the basic test, one frame_done.
- reset driven low at cycle 5 → all outputs 0 immediately, no frame_done. A subsequent start produces a full clean frame beginning at pixel 0.
- With FRAME_READER_GRAY_EN defined, BRAM[0]=24'h4080C0 (R=C0, G=80, B=40) → out_din=24'h808080. Undefined → out_din=24'h4080C0.
